// File: rtl/alu_share_arbiter_if.sv
// Bundle between the two operand requesters, the shared ALU and the response consumer.
// slave = arbiter side, master = environment side (requesters, ALU, consumer).
interface alu_share_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
);
  logic             Req0_Valid;
  logic             Req0_Ready;
  logic [WIDTH-1:0] Req0_A;
  logic [WIDTH-1:0] Req0_B;
  logic [SEL_W-1:0] Req0_S;
  logic             Req1_Valid;
  logic             Req1_Ready;
  logic [WIDTH-1:0] Req1_A;
  logic [WIDTH-1:0] Req1_B;
  logic [SEL_W-1:0] Req1_S;
  logic [WIDTH-1:0] Alu_A;
  logic [WIDTH-1:0] Alu_B;
  logic [SEL_W-1:0] Alu_S;
  logic [WIDTH-1:0] Alu_YH;
  logic [WIDTH-1:0] Alu_YL;
  logic             Rsp_Valid;
  logic             Rsp_Ready;
  logic             Rsp_Id;
  logic [WIDTH-1:0] Rsp_YH;
  logic [WIDTH-1:0] Rsp_YL;
  logic             Busy;
  logic [7:0]       Done_Cnt0;
  logic [7:0]       Done_Cnt1;

  modport slave (
    input  Req0_Valid, Req0_A, Req0_B, Req0_S,
    input  Req1_Valid, Req1_A, Req1_B, Req1_S,
    input  Alu_YH, Alu_YL, Rsp_Ready,
    output Req0_Ready, Req1_Ready, Alu_A, Alu_B, Alu_S,
    output Rsp_Valid, Rsp_Id, Rsp_YH, Rsp_YL, Busy, Done_Cnt0, Done_Cnt1
  );

  modport master (
    output Req0_Valid, Req0_A, Req0_B, Req0_S,
    output Req1_Valid, Req1_A, Req1_B, Req1_S,
    output Alu_YH, Alu_YL, Rsp_Ready,
    input  Req0_Ready, Req1_Ready, Alu_A, Alu_B, Alu_S,
    input  Rsp_Valid, Rsp_Id, Rsp_YH, Rsp_YL, Busy, Done_Cnt0, Done_Cnt1
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters: latch operands,
// hold them for LAT cycles, capture YH/YL and hand them back over a valid/ready response.
module alu_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3,
  parameter int LAT   = 1
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  alu_share_arbiter_if.slave   bus
);
  // LAT of 0 behaves as 1; the wait counter is 4 bits wide.
  localparam int         LAT_EFF  = (LAT < 1) ? 1 : ((LAT > 15) ? 15 : LAT);
  localparam logic [3:0] LAT_LOAD = 4'(LAT_EFF);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic             last_grant_reg, last_grant_next;
  logic [WIDTH-1:0] alu_a_reg, alu_a_next;
  logic [WIDTH-1:0] alu_b_reg, alu_b_next;
  logic [SEL_W-1:0] alu_s_reg, alu_s_next;
  logic             rsp_id_reg, rsp_id_next;
  logic [WIDTH-1:0] rsp_yh_reg, rsp_yh_next;
  logic [WIDTH-1:0] rsp_yl_reg, rsp_yl_next;
  logic [7:0]       done_cnt_reg [2];

  logic [1:0]       req_valid;
  logic [1:0]       grant;
  logic             winner;
  logic             rsp_fire;

  // On contention the requester that was not served last wins.
  always_comb begin
    req_valid = {bus.Req1_Valid, bus.Req0_Valid};
    winner    = (req_valid == 2'b11) ? ~last_grant_reg : req_valid[1];
    grant     = 2'b00;
    if (state_reg == IDLE && req_valid[winner]) begin
      grant[winner] = 1'b1;
    end
    rsp_fire = (state_reg == RESP) && bus.Rsp_Ready;
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    last_grant_next = last_grant_reg;
    alu_a_next      = alu_a_reg;
    alu_b_next      = alu_b_reg;
    alu_s_next      = alu_s_reg;
    rsp_id_next     = rsp_id_reg;
    rsp_yh_next     = rsp_yh_reg;
    rsp_yl_next     = rsp_yl_reg;
    case (state_reg)
      IDLE: begin
        if (|grant) begin
          alu_a_next      = winner ? bus.Req1_A : bus.Req0_A;
          alu_b_next      = winner ? bus.Req1_B : bus.Req0_B;
          alu_s_next      = winner ? bus.Req1_S : bus.Req0_S;
          rsp_id_next     = winner;
          last_grant_next = winner;
          cnt_next        = LAT_LOAD;
          state_next      = EXEC;
        end
      end
      EXEC: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          rsp_yh_next = bus.Alu_YH;
          rsp_yl_next = bus.Alu_YL;
          state_next  = RESP;
        end
      end
      RESP: begin
        if (bus.Rsp_Ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      last_grant_reg <= 1'b1;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_s_reg      <= '0;
      rsp_id_reg     <= 1'b0;
      rsp_yh_reg     <= '0;
      rsp_yl_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      last_grant_reg <= last_grant_next;
      alu_a_reg      <= alu_a_next;
      alu_b_reg      <= alu_b_next;
      alu_s_reg      <= alu_s_next;
      rsp_id_reg     <= rsp_id_next;
      rsp_yh_reg     <= rsp_yh_next;
      rsp_yl_reg     <= rsp_yl_next;
    end
  end

  // Completion counters, one per requester, wrapping at 256.
  for (genvar gi = 0; gi < 2; gi++) begin : g_done
    always_ff @(posedge Clk) begin
      if (!Rst_n) begin
        done_cnt_reg[gi] <= 8'd0;
      end else if (rsp_fire && (rsp_id_reg == 1'(gi))) begin
        done_cnt_reg[gi] <= done_cnt_reg[gi] + 8'd1;
      end
    end
  end

  assign bus.Req0_Ready = grant[0];
  assign bus.Req1_Ready = grant[1];
  assign bus.Alu_A      = alu_a_reg;
  assign bus.Alu_B      = alu_b_reg;
  assign bus.Alu_S      = alu_s_reg;
  assign bus.Rsp_Valid  = (state_reg == RESP);
  assign bus.Rsp_Id     = rsp_id_reg;
  assign bus.Rsp_YH     = rsp_yh_reg;
  assign bus.Rsp_YL     = rsp_yl_reg;
  assign bus.Busy       = (state_reg != IDLE);
  assign bus.Done_Cnt0  = done_cnt_reg[0];
  assign bus.Done_Cnt1  = done_cnt_reg[1];
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: randomized requests, a slow-settling ALU stub
// and a cycle-level reference model of arbitration, latency and completion counts.
module tb_alu_share_arbiter;
  localparam int LAT = 4;

  logic Clk = 1'b0;
  logic Rst_n;
  always #5 Clk = ~Clk;

  alu_share_arbiter_if #(.WIDTH(8), .SEL_W(3)) ifc ();

  alu_share_arbiter #(.WIDTH(8), .SEL_W(3), .LAT(LAT)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (ifc)
  );

  // ALU stub: YL=A+B, YH=A^B, but only about 2.5 cycles after the operands change.
  logic [18:0] stub_prev = '0;
  int          stub_age  = 0;
  always @(negedge Clk) begin
    if ({ifc.Alu_A, ifc.Alu_B, ifc.Alu_S} != stub_prev) begin
      stub_prev = {ifc.Alu_A, ifc.Alu_B, ifc.Alu_S};
      stub_age  = 0;
    end else if (stub_age < 15) begin
      stub_age++;
    end
  end
  assign ifc.Alu_YL = (stub_age >= 2) ? 8'(ifc.Alu_A + ifc.Alu_B) : 8'hA5;
  assign ifc.Alu_YH = (stub_age >= 2) ? (ifc.Alu_A ^ ifc.Alu_B) : 8'h5A;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Reference model state.
  typedef struct packed {
    logic       id;
    logic [7:0] yh;
    logic [7:0] yl;
  } rsp_t;

  rsp_t       exp_q[$];
  int         grant_log[$];
  bit         m_busy    = 1'b0;
  int         m_age     = 0;
  bit         m_last    = 1'b1;
  bit         m_id      = 1'b0;
  logic [7:0] m_cnt0    = 8'd0;
  logic [7:0] m_cnt1    = 8'd0;
  logic [7:0] m_alu_a   = 8'd0;
  logic [7:0] m_alu_b   = 8'd0;
  logic [2:0] m_alu_s   = 3'd0;
  bit         m_rst_chk = 1'b1;

  always @(negedge Clk) begin : monitor
    bit   er0, er1, ev;
    rsp_t r;
    ev  = m_busy && (m_age > LAT);
    er0 = !m_busy && ifc.Req0_Valid && (!ifc.Req1_Valid || m_last);
    er1 = !m_busy && ifc.Req1_Valid && (!ifc.Req0_Valid || !m_last);
    chk("req0_ready", ifc.Req0_Ready, er0);
    chk("req1_ready", ifc.Req1_Ready, er1);
    chk("busy", ifc.Busy, m_busy);
    chk("rsp_valid", ifc.Rsp_Valid, ev);
    chk("done_cnt0", ifc.Done_Cnt0, m_cnt0);
    chk("done_cnt1", ifc.Done_Cnt1, m_cnt1);
    chk("alu_a", ifc.Alu_A, m_alu_a);
    chk("alu_b", ifc.Alu_B, m_alu_b);
    chk("alu_s", ifc.Alu_S, m_alu_s);
    if (m_rst_chk) begin
      chk("reset_rsp_id", ifc.Rsp_Id, 0);
      chk("reset_rsp_yh", ifc.Rsp_YH, 0);
      chk("reset_rsp_yl", ifc.Rsp_YL, 0);
    end
    if (ifc.Rsp_Valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        fail_now("rsp_unexpected");
      end else begin
        r = exp_q[0];
        chk("rsp_id", ifc.Rsp_Id, r.id);
        chk("rsp_yh", ifc.Rsp_YH, r.yh);
        chk("rsp_yl", ifc.Rsp_YL, r.yl);
        if (ifc.Rsp_Ready) void'(exp_q.pop_front());
      end
    end
    // Advance the model to the state after the coming rising edge.
    m_rst_chk = 1'b0;
    if (!Rst_n) begin
      m_busy = 0; m_age = 0; m_last = 1; m_id = 0;
      m_cnt0 = 0; m_cnt1 = 0; m_alu_a = 0; m_alu_b = 0; m_alu_s = 0;
      exp_q.delete();
      m_rst_chk = 1'b1;
    end else if (er0 || er1) begin
      m_alu_a = er1 ? ifc.Req1_A : ifc.Req0_A;
      m_alu_b = er1 ? ifc.Req1_B : ifc.Req0_B;
      m_alu_s = er1 ? ifc.Req1_S : ifc.Req0_S;
      exp_q.push_back('{id: er1, yh: m_alu_a ^ m_alu_b, yl: 8'(m_alu_a + m_alu_b)});
      grant_log.push_back(int'(er1));
      m_last = er1; m_id = er1; m_busy = 1; m_age = 1;
    end else if (m_busy) begin
      if (ev && ifc.Rsp_Ready) begin
        m_busy = 0;
        if (m_id) m_cnt1++; else m_cnt0++;
      end else if (m_age <= LAT) begin
        m_age++;
      end
    end
  end

  // Stimulus side.
  int acc0 = 0;
  int acc1 = 0;

  task automatic step();
    bit a0, a1;
    @(negedge Clk);
    a0 = ifc.Req0_Valid && ifc.Req0_Ready;
    a1 = ifc.Req1_Valid && ifc.Req1_Ready;
    @(posedge Clk);
    #1;
    if (a0) begin ifc.Req0_Valid = 1'b0; acc0++; end
    if (a1) begin ifc.Req1_Valid = 1'b0; acc1++; end
  endtask

  task automatic set_req(input int who, input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    if (who == 0) begin
      ifc.Req0_Valid = 1'b1; ifc.Req0_A = a; ifc.Req0_B = b; ifc.Req0_S = s;
    end else begin
      ifc.Req1_Valid = 1'b1; ifc.Req1_A = a; ifc.Req1_B = b; ifc.Req1_S = s;
    end
  endtask

  task automatic issue(input int who);
    set_req(who, 8'($urandom), 8'($urandom), 3'($urandom));
  endtask

  task automatic wait_quiet(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!ifc.Req0_Valid && !ifc.Req1_Valid && !m_busy) return;
      step();
    end
    fail_now(name);
  endtask

  task automatic do_reset();
    ifc.Req0_Valid = 1'b0;
    ifc.Req1_Valid = 1'b0;
    Rst_n = 1'b0;
    step();
    step();
    Rst_n = 1'b1;
  endtask

  initial begin
    int start0, start1, guard;
    Rst_n = 1'b0;
    ifc.Req0_Valid = 1'b0; ifc.Req0_A = '0; ifc.Req0_B = '0; ifc.Req0_S = '0;
    ifc.Req1_Valid = 1'b0; ifc.Req1_A = '0; ifc.Req1_B = '0; ifc.Req1_S = '0;
    ifc.Rsp_Ready = 1'b1;
    repeat (3) step();
    Rst_n = 1'b1;
    step();

    // Single directed request.
    set_req(0, 8'h12, 8'h34, 3'b001);
    wait_quiet("single_op", 50);
    chk("single_done_cnt0", ifc.Done_Cnt0, 1);

    // Both requesters valid after reset: grants must alternate starting with 0.
    do_reset();
    grant_log.delete();
    start0 = acc0; start1 = acc1; guard = 0;
    while ((acc0 - start0 < 3 || acc1 - start1 < 3) && guard < 200) begin
      if (!ifc.Req0_Valid && acc0 - start0 < 3) issue(0);
      if (!ifc.Req1_Valid && acc1 - start1 < 3) issue(1);
      step();
      guard++;
    end
    wait_quiet("alternate", 50);
    chk("alt_grant_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk($sformatf("alt_grant_%0d", i), grant_log[i], i % 2);
    chk("alt_done_cnt0", ifc.Done_Cnt0, 3);
    chk("alt_done_cnt1", ifc.Done_Cnt1, 3);

    // Response stall with requester 1 waiting.
    ifc.Rsp_Ready = 1'b0;
    issue(0);
    guard = 0;
    while (!(m_busy && m_age > LAT) && guard < 50) begin step(); guard++; end
    if (guard >= 50) fail_now("stall_reach_resp");
    issue(1);
    repeat (10) step();
    chk("stall_req1_pending", ifc.Req1_Valid, 1);
    ifc.Rsp_Ready = 1'b1;
    wait_quiet("stall_release", 50);

    // Reset while an operation is executing.
    do_reset();
    issue(0);
    guard = 0;
    while (ifc.Req0_Valid && guard < 20) begin step(); guard++; end
    step();
    Rst_n = 1'b0;
    step();
    Rst_n = 1'b1;
    repeat (LAT + 4) step();
    chk("midreset_done_cnt0", ifc.Done_Cnt0, 0);
    chk("midreset_rsp_valid", ifc.Rsp_Valid, 0);

    // 256 requester-0 operations: counter 0 wraps, counter 1 untouched.
    start0 = acc0; guard = 0;
    while (acc0 - start0 < 256 && guard < 4000) begin
      if (!ifc.Req0_Valid && acc0 - start0 < 255) issue(0);
      else if (!ifc.Req0_Valid && acc0 - start0 == 255 && !m_busy) issue(0);
      step();
      guard++;
    end
    wait_quiet("wrap", 50);
    chk("wrap_done_cnt0", ifc.Done_Cnt0, 0);
    chk("wrap_done_cnt1", ifc.Done_Cnt1, 0);

    // Random traffic: random raises, early drops and consumer back-pressure.
    for (int i = 0; i < 600; i++) begin
      if (!ifc.Req0_Valid && $urandom_range(0, 2) == 0) issue(0);
      else if (ifc.Req0_Valid && $urandom_range(0, 15) == 0) ifc.Req0_Valid = 1'b0;
      if (!ifc.Req1_Valid && $urandom_range(0, 2) == 0) issue(1);
      else if (ifc.Req1_Valid && $urandom_range(0, 15) == 0) ifc.Req1_Valid = 1'b0;
      ifc.Rsp_Ready = ($urandom_range(0, 9) < 7);
      step();
    end
    ifc.Rsp_Ready = 1'b1;
    wait_quiet("random_drain", 200);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1, "global timeout");
  end
endmodule
